// File: rtl/time_keeper_if.sv
// Button inputs and display/status outputs of the timekeeping core.
// The master side presses the buttons and watches the display; the slave is the core.
interface time_keeper_if;
    logic        btn_mode;
    logic        btn_inc;
    logic [11:0] data_show;
    logic [2:0]  byte_status;
    logic        second_tick;
    logic [1:0]  set_mode;

    modport master (
        output btn_mode, btn_inc,
        input  data_show, byte_status, second_tick, set_mode
    );

    modport slave (
        input  btn_mode, btn_inc,
        output data_show, byte_status, second_tick, set_mode
    );
endinterface

// File: rtl/time_keeper.sv
// Digital clock timekeeping core: 1 Hz prescaler, hh:mm:ss counters,
// two-button time setting with synchronized and debounced buttons, and a display scan index.
module time_keeper #(
    parameter int unsigned TICK_DIV   = 10000000,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned DEB_CYCLES = 65536
) (
    input  logic          clock,
    input  logic          reset,
    time_keeper_if.slave  tk
);
    localparam int unsigned NB     = 2;
    localparam int unsigned PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_e;

    logic [NB-1:0]    raw, meta, sync, stable, press;
    logic [DEB_W-1:0] deb_cnt [NB];

    mode_e             state;
    logic [PRE_W-1:0]  presc;
    logic [SCAN_W-1:0] scan_div;
    logic [2:0]        scan_idx;
    logic              tick;
    logic [4:0]        hr;
    logic [5:0]        mn;
    logic [5:0]        sec;

    logic mode_p, inc_p;

    // Bit 0 is the mode button and bit 1 is the increment button.
    assign raw    = {tk.btn_inc, tk.btn_mode};
    assign mode_p = press[0];
    assign inc_p  = press[1];

    // Synchronize and debounce each button, then emit a one-cycle pulse on an accepted press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta   <= '0;
            sync   <= '0;
            stable <= '0;
            press  <= '0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            meta  <= raw;
            sync  <= meta;
            press <= '0;
            for (int i = 0; i < NB; i++) begin
                if (sync[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_cnt[i] <= '0;
                    stable[i]  <= sync[i];
                    press[i]   <= sync[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Mode FSM, prescaler and time counters. A mode press outranks inc and a pending tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            presc <= '0;
            tick  <= 1'b0;
            hr    <= '0;
            mn    <= '0;
            sec   <= '0;
        end else begin
            tick <= 1'b0;
            unique case (state)
                RUN: begin
                    if (mode_p) begin
                        state <= SET_HOUR;
                        presc <= '0;
                    end else if (presc == PRE_W'(TICK_DIV - 1)) begin
                        presc <= '0;
                        tick  <= 1'b1;
                        if (sec == 6'd59) begin
                            sec <= '0;
                            if (mn == 6'd59) begin
                                mn <= '0;
                                hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
                            end else begin
                                mn <= mn + 6'd1;
                            end
                        end else begin
                            sec <= sec + 6'd1;
                        end
                    end else begin
                        presc <= presc + PRE_W'(1);
                    end
                end
                SET_HOUR: begin
                    presc <= '0;
                    if (mode_p) begin
                        state <= SET_MIN;
                    end else if (inc_p) begin
                        hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
                    end
                end
                SET_MIN: begin
                    presc <= '0;
                    if (mode_p) begin
                        state <= RUN;
                        sec   <= '0;
                    end else if (inc_p) begin
                        mn  <= (mn == 6'd59) ? 6'd0 : mn + 6'd1;
                        sec <= '0;
                    end
                end
                default: begin
                    state <= RUN;
                    presc <= '0;
                end
            endcase
        end
    end

    // Display scan index runs in every mode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_div <= '0;
            scan_idx <= '0;
        end else if (scan_div == SCAN_W'(SCAN_DIV - 1)) begin
            scan_div <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            scan_div <= scan_div + SCAN_W'(1);
        end
    end

    assign tk.data_show   = {1'b0, hr, mn};
    assign tk.byte_status = scan_idx;
    assign tk.second_tick = tick;
    assign tk.set_mode    = state;

endmodule
